// File: rtl/gba_pix_pkg.sv
// Shared definitions for the GBA pixel path: packed FIFO word layout and pixel type.
package gba_pix_pkg;

   localparam int GBA_LINE_PIXELS = 240;

   localparam int WORD_SOF     = 31;
   localparam int WORD_SOL     = 30;
   localparam int WORD_PIX1_HI = 29;
   localparam int WORD_PIX1_LO = 15;
   localparam int WORD_PIX0_HI = 14;
   localparam int WORD_PIX0_LO = 0;

   typedef logic [14:0] rgb555_t;

   function automatic logic [31:0] pack_word(input logic    sof,
                                             input logic    sol,
                                             input rgb555_t pix1,
                                             input rgb555_t pix0);
      logic [31:0] w;
      w                            = '0;
      w[WORD_SOF]                  = sof;
      w[WORD_SOL]                  = sol;
      w[WORD_PIX1_HI:WORD_PIX1_LO] = pix1;
      w[WORD_PIX0_HI:WORD_PIX0_LO] = pix0;
      return w;
   endfunction

endpackage

// File: rtl/fifo_pixel_packer.sv
// Packs pairs of RGB555 pixels into 32-bit words for the dual-clock FIFO write side,
// tracking line framing; one-word output register, in_ready drops only while it is stuck on wfull.
module fifo_pixel_packer
   import gba_pix_pkg::*;
#(
   parameter int LINE_PIXELS = GBA_LINE_PIXELS,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             wrst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [14:0]      in_data,
   input  logic             in_sol,
   input  logic             in_sof,
   output logic [31:0]      fifo_wdata,
   output logic             fifo_winc,
   input  logic             fifo_wfull,
   output logic [7:0]       line_cnt,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;

   localparam int               CNT_W    = $clog2(LINE_PIXELS + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_PIXELS);

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] pix_cnt, pix_cnt_nxt;
   rgb555_t          pix0_q;
   logic             sof_q, sol_q;
   logic             word_valid;
   logic [31:0]      word_q, word_nxt;

   logic accept, sol_eff;
   logic load_word, take_pix0, new_sof, new_sol;
   logic err_inc, line_inc, line_clr;

   assign in_ready   = ~(word_valid & fifo_wfull);
   assign fifo_winc  = word_valid & ~fifo_wfull;
   assign fifo_wdata = word_q;

   assign accept  = in_valid & in_ready;
   assign sol_eff = in_sol | in_sof;

   always_comb begin
      state_nxt   = state;
      pix_cnt_nxt = pix_cnt;
      word_nxt    = word_q;
      load_word   = 1'b0;
      take_pix0   = 1'b0;
      new_sof     = 1'b0;
      new_sol     = 1'b0;
      err_inc     = 1'b0;
      line_inc    = 1'b0;
      line_clr    = 1'b0;

      if (accept) begin
         if (sol_eff) begin
            // An open line ends early; a held pix0 leaves as a half word in the
            // same cycle the new line's first pixel takes its place.
            if (state != ST_IDLE) begin
               err_inc = 1'b1;
            end
            if (state == ST_HI) begin
               load_word = 1'b1;
               word_nxt  = pack_word(sof_q, sol_q, '0, pix0_q);
            end
            take_pix0   = 1'b1;
            new_sof     = in_sof;
            new_sol     = 1'b1;
            pix_cnt_nxt = CNT_ONE;
            line_clr    = in_sof;
            state_nxt   = ST_HI;
         end else begin
            case (state)
               ST_LO: begin
                  take_pix0   = 1'b1;
                  pix_cnt_nxt = pix_cnt + CNT_ONE;
                  state_nxt   = ST_HI;
               end
               ST_HI: begin
                  load_word   = 1'b1;
                  word_nxt    = pack_word(sof_q, sol_q, in_data, pix0_q);
                  pix_cnt_nxt = pix_cnt + CNT_ONE;
                  if ((pix_cnt + CNT_ONE) == CNT_LAST) begin
                     line_inc  = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     state_nxt = ST_LO;
                  end
               end
               default: begin
                  err_inc = 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge wrst_n) begin
      if (!wrst_n) begin
         state   <= ST_IDLE;
         pix_cnt <= '0;
         pix0_q  <= '0;
         sof_q   <= 1'b0;
         sol_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pix_cnt <= pix_cnt_nxt;
         if (take_pix0) begin
            pix0_q <= in_data;
            sof_q  <= new_sof;
            sol_q  <= new_sol;
         end
      end
   end

   // Loading only happens on an accepted pixel, so the register is empty or draining.
   always_ff @(posedge clk or negedge wrst_n) begin
      if (!wrst_n) begin
         word_valid <= 1'b0;
         word_q     <= '0;
      end else begin
         word_valid <= load_word | (word_valid & ~fifo_winc);
         if (load_word) begin
            word_q <= word_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge wrst_n) begin
      if (!wrst_n) begin
         line_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         if (line_clr) begin
            line_cnt <= '0;
         end else if (line_inc) begin
            line_cnt <= line_cnt + 8'd1;
         end
         if (err_inc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_pixel_packer.sv
// Scoreboard bench for fifo_pixel_packer: expected words queued as pixels are driven,
// compared as fifo_winc fires.
module tb_fifo_pixel_packer;

   logic        clk = 1'b0;
   logic        wrst_n;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] in_data;
   logic        in_sol;
   logic        in_sof;
   logic [31:0] fifo_wdata;
   logic        fifo_winc;
   logic        fifo_wfull;
   logic [7:0]  line_cnt;
   logic [7:0]  err_cnt;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          wr_cnt = 0;
   int          wr0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_w;

   always #5 clk = ~clk;

   fifo_pixel_packer #(.LINE_PIXELS(240), .ERR_W(8)) dut (
      .clk        (clk),
      .wrst_n     (wrst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sol     (in_sol),
      .in_sof     (in_sof),
      .fifo_wdata (fifo_wdata),
      .fifo_winc  (fifo_winc),
      .fifo_wfull (fifo_wfull),
      .line_cnt   (line_cnt),
      .err_cnt    (err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic sof, input logic sol,
                                      input logic [14:0] p1, input logic [14:0] p0);
      return {sof, sol, p1, p0};
   endfunction

   function automatic logic [14:0] pv(input int i);
      if (i == 0) return 15'h0001;
      if (i == 1) return 15'h7FFF;
      return 15'(i * 37 + 11);
   endfunction

   always @(negedge clk) begin
      if (wrst_n && fifo_winc) begin
         wr_cnt++;
         check("winc_while_full", {31'b0, fifo_wfull}, 32'd0);
         if (exp_q.size() == 0) begin
            check("winc_unexpected", {31'b0, fifo_winc}, 32'd0);
         end else begin
            exp_w = exp_q.pop_front();
            check("word", fifo_wdata, exp_w);
         end
      end
   end

   task automatic send_pix(input logic [14:0] d, input logic sol, input logic sof);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_sol   = sol;
      in_sof   = sof;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sol   = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic stall_fifo(input int cycles);
      fifo_wfull = 1'b1;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         check("stall_ready", {31'b0, in_ready}, 32'd0);
         check("stall_winc", {31'b0, fifo_winc}, 32'd0);
      end
      @(posedge clk);
      #1;
      fifo_wfull = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      wrst_n     = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_sol     = 1'b0;
      in_sof     = 1'b0;
      fifo_wfull = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_ready", {31'b0, in_ready}, 32'd1);
      check("rst_winc", {31'b0, fifo_winc}, 32'd0);
      check("rst_wdata", fifo_wdata, 32'd0);
      check("rst_line", {24'b0, line_cnt}, 32'd0);
      check("rst_err", {24'b0, err_cnt}, 32'd0);

      @(posedge clk);
      #1;
      wrst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full line with sof on pixel 0 and a 10-cycle wfull hold in the middle.
      wr0 = wr_cnt;
      for (int i = 0; i < 240; i++) begin
         if (i % 2 == 1) exp_q.push_back(mk(i == 1, i == 1, pv(i), pv(i - 1)));
         if (i == 100) begin
            fork
               stall_fifo(10);
               send_pix(pv(i), 1'b0, 1'b0);
            join
         end else begin
            send_pix(pv(i), i == 0, i == 0);
         end
      end
      repeat (3) @(negedge clk);
      check("line_writes", 32'(wr_cnt - wr0), 32'd120);
      check("line_sb_empty", 32'(exp_q.size()), 32'd0);
      check("line_cnt_1", {24'b0, line_cnt}, 32'd1);
      check("line_err_0", {24'b0, err_cnt}, 32'd0);

      // Line end returned to IDLE: a stray pixel is a framing error.
      @(posedge clk);
      #1;
      send_pix(15'h1234, 1'b0, 1'b0);
      check("stray_err", {24'b0, err_cnt}, 32'd1);

      // sof without sol starts a line with both flags; early sol after 5 pixels.
      send_pix(15'h0A0A, 1'b0, 1'b1);
      exp_q.push_back(mk(1'b1, 1'b1, 15'h0B0B, 15'h0A0A));
      send_pix(15'h0B0B, 1'b0, 1'b0);
      check("sof_clr_line", {24'b0, line_cnt}, 32'd0);
      send_pix(15'h0C0C, 1'b0, 1'b0);
      exp_q.push_back(mk(1'b0, 1'b0, 15'h0D0D, 15'h0C0C));
      send_pix(15'h0D0D, 1'b0, 1'b0);
      send_pix(15'h0E0E, 1'b0, 1'b0);
      exp_q.push_back(mk(1'b0, 1'b0, 15'h0000, 15'h0E0E));
      send_pix(15'h0F0F, 1'b1, 1'b0);
      check("early_err", {24'b0, err_cnt}, 32'd2);

      // Second pixel of the new line; its word is held by wfull then killed by reset.
      send_pix(15'h1111, 1'b0, 1'b0);
      fifo_wfull = 1'b1;
      @(negedge clk);
      check("hold_winc", {31'b0, fifo_winc}, 32'd0);
      check("hold_sb_empty", 32'(exp_q.size()), 32'd0);
      wrst_n = 1'b0;
      @(negedge clk);
      check("midrst_winc", {31'b0, fifo_winc}, 32'd0);
      check("midrst_line", {24'b0, line_cnt}, 32'd0);
      check("midrst_err", {24'b0, err_cnt}, 32'd0);
      check("midrst_wdata", fifo_wdata, 32'd0);
      check("midrst_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      fifo_wfull = 1'b0;
      wrst_n     = 1'b1;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;

      // Pixels without sol after reset are all discarded.
      wr0 = wr_cnt;
      for (int i = 0; i < 3; i++) send_pix(15'(100 + i), 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("idle_err_3", {24'b0, err_cnt}, 32'd3);
      check("idle_no_write", 32'(wr_cnt - wr0), 32'd0);

      // Saturation of the error counter.
      @(posedge clk);
      #1;
      for (int i = 0; i < 252; i++) send_pix(15'(i), 1'b0, 1'b0);
      check("err_reach_max", {24'b0, err_cnt}, 32'd255);
      for (int i = 0; i < 5; i++) send_pix(15'(i), 1'b0, 1'b0);
      check("err_saturate", {24'b0, err_cnt}, 32'd255);
      check("end_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
